config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LENGTH, default 4096, meaning the total number of configuration bits in the core's serial chain (range 1..65535).
REQ-002 SHALL have parameter WORD_WIDTH, default 32, meaning the width of a bitstream word (range 1..64).
REQ-003 SHALL have parameter CLEAR_CYCLES, default 4, meaning the number of cycles cfg_nreset is held low before loading (range 1..255).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; rising edge is active; the core's config_clock is driven from the same net.
REQ-005 SHALL have port nreset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin configuration.
REQ-007 SHALL have port abort, input, 1 bit: a request to abandon configuration.
REQ-008 SHALL have port word_data, input, WORD_WIDTH bits: the bitstream word, LSB shifted first.
REQ-009 SHALL have port word_valid, input, 1 bit: word_data is valid.
REQ-010 SHALL have port word_ready, output, 1 bit: the loader accepts the word this cycle.
REQ-011 SHALL have port cfg_bit, output, 1 bit: the serial bit to the core config_in.
REQ-012 SHALL have port cfg_enable, output, 1 bit: the core config_enable.
REQ-013 SHALL have port cfg_nreset, output, 1 bit: the core config_nreset, active-low.
REQ-014 SHALL have port core_enable, output, 1 bit: the core user-logic enable.
REQ-015 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle pulse when loading completes.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, LOAD and DONE; all outputs are registered except word_ready.
REQ-018 SHALL move from IDLE to CLEAR when start=1 and abort=0; in that same edge it SHALL clear core_enable, the bit counter and the word buffer.
REQ-019 SHALL ignore start when the state is not IDLE.
REQ-020 SHALL hold cfg_nreset=0 in CLEAR for exactly CLEAR_CYCLES cycles, then enter LOAD with cfg_nreset=1.
REQ-021 SHALL transfer a word on a clock edge only when word_valid=1 and word_ready=1 in the same cycle.
REQ-022 SHALL, in LOAD, assert word_ready when the buffer is empty, or when the buffer is presenting its final bit and that bit is not chain bit CHAIN_LENGTH-1; word_ready SHALL be 0 in all other states.
REQ-023 SHALL, in the cycle after a word transfer, present buffer bit 0 on cfg_bit with cfg_enable=1; the core shifts on that edge.
REQ-024 SHALL present buffer bits 1..WORD_WIDTH-1 on consecutive cycles; a continuous word_valid stream SHALL produce cfg_enable=1 with no bubbles.
REQ-025 SHALL, when the buffer is empty, drive cfg_enable=0 and hold cfg_bit at 0; a stall has no length limit and loses no bits.
REQ-026 SHALL maintain a bit counter of width clog2(CHAIN_LENGTH+1) that increments on each cfg_enable=1 cycle.
REQ-027 SHALL, after presenting chain bit CHAIN_LENGTH-1, enter DONE on the next edge, discard any unshifted buffer bits, and not accept further words.
REQ-028 SHALL pulse done=1 and set core_enable=1 for one cycle in DONE, then return to IDLE with core_enable held at 1.
REQ-029 SHALL, when abort=1 in any state, go to IDLE on the next edge with cfg_enable=0, cfg_nreset=1, core_enable=0, an empty buffer and done=0; abort takes priority over start and over completion in the same cycle.
REQ-030 SHALL handle a non-multiple CHAIN_LENGTH: the final word is partially shifted and its upper bits are ignored.

Reset
REQ-031 SHALL, while nreset=0, asynchronously force state=IDLE, cfg_bit=0, cfg_enable=0, cfg_nreset=0, core_enable=0, busy=0, done=0, word_ready=0, counter=0 and buffer empty.
REQ-032 SHALL drive cfg_nreset=1 on the first clock edge after nreset deasserts, while in IDLE.
REQ-033 SHALL treat reset during LOAD as an abandoned load: after reset the core is unconfigured and core_enable=0 until a new complete load.

Verification
REQ-034 Full load: CHAIN_LENGTH=40, WORD_WIDTH=8, CLEAR_CYCLES=2, words 0x01,0x02,0x03,0x04,0x05 streamed continuously -> cfg_nreset low for 2 cycles, then 40 consecutive cfg_enable cycles carrying the LSB-first bits, done pulses once, and core_enable=1.
REQ-035 Partial last word: CHAIN_LENGTH=20, WORD_WIDTH=8, 3 words -> exactly 20 enable cycles; bits 4..7 of word 3 are never shifted; word_ready stays 0 after the third transfer.
REQ-036 Stall: word_valid drops for 5 cycles after word 2 -> cfg_enable=0 for those cycles, the bit order is unbroken, and the total enable count is CHAIN_LENGTH.
REQ-037 Abort at bit 17 -> next cycle state is IDLE, cfg_enable=0 and core_enable=0; a following start reloads from bit 0 with a new CLEAR phase.
REQ-038 nreset asserted mid-LOAD -> all outputs reach their reset values immediately without waiting for a clock; start is ignored while nreset=0.
REQ-039 Start during LOAD and start coincident with abort -> no restart; abort wins and the state becomes IDLE.

Source files
------------

// File: rtl/config_loader.sv
// Serial configuration loader: holds the core in configuration reset for a
// fixed number of cycles, then streams bitstream words LSB-first into the
// core's config chain and enables the user logic once the whole chain is shifted.
module config_loader #(
  parameter int CHAIN_LENGTH = 4096,
  parameter int WORD_WIDTH   = 32,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_bit,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  output logic                  core_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int IDX_W = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);
  localparam logic [7:0]       LAST_CLR = 8'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [7:0]            clr_q, clr_d;
  logic                  cfg_bit_q, cfg_bit_d;
  logic                  cfg_enable_q, cfg_enable_d;
  logic                  cfg_nreset_q, cfg_nreset_d;
  logic                  core_enable_q, core_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic final_buf_bit;
  logic last_chain_bit;
  logic xfer;

  // cfg_enable_q doubles as "buffer is presenting a bit"; cnt_q is the chain
  // index of that bit because it counts the enable cycles already completed.
  assign final_buf_bit  = cfg_enable_q && (idx_q == LAST_IDX);
  assign last_chain_bit = cfg_enable_q && (cnt_q == LAST_BIT);
  assign word_ready     = (state_q == LOAD) &&
                          (!cfg_enable_q || (final_buf_bit && !last_chain_bit));
  assign xfer           = word_valid && word_ready;

  assign cfg_bit     = cfg_bit_q;
  assign cfg_enable  = cfg_enable_q;
  assign cfg_nreset  = cfg_nreset_q;
  assign core_enable = core_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // State and datapath registers, forced to a safe unconfigured state on reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      buf_q         <= '0;
      clr_q         <= '0;
      cfg_bit_q     <= 1'b0;
      cfg_enable_q  <= 1'b0;
      cfg_nreset_q  <= 1'b0;
      core_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      clr_q         <= clr_d;
      cfg_bit_q     <= cfg_bit_d;
      cfg_enable_q  <= cfg_enable_d;
      cfg_nreset_q  <= cfg_nreset_d;
      core_enable_q <= core_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic; abort overrides start and completion.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CLEAR;
        CLEAR:   if (clr_q == LAST_CLR) state_d = LOAD;
        LOAD:    if (last_chain_bit) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, the shift buffer and the counters.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    clr_d         = clr_q;
    cfg_bit_d     = cfg_bit_q;
    cfg_enable_d  = cfg_enable_q;
    cfg_nreset_d  = cfg_nreset_q;
    core_enable_d = core_enable_q;
    done_d        = 1'b0;
    if (abort) begin
      cnt_d         = '0;
      idx_d         = '0;
      buf_d         = '0;
      clr_d         = '0;
      cfg_bit_d     = 1'b0;
      cfg_enable_d  = 1'b0;
      cfg_nreset_d  = 1'b1;
      core_enable_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cfg_nreset_d = 1'b1;
          if (start) begin
            cfg_nreset_d  = 1'b0;
            core_enable_d = 1'b0;
            cnt_d         = '0;
            idx_d         = '0;
            buf_d         = '0;
            clr_d         = '0;
            cfg_bit_d     = 1'b0;
            cfg_enable_d  = 1'b0;
          end
        end
        CLEAR: begin
          if (clr_q == LAST_CLR) cfg_nreset_d = 1'b1;
          else                   clr_d = clr_q + 8'd1;
        end
        LOAD: begin
          if (cfg_enable_q) cnt_d = cnt_q + CNT_W'(1);
          if (last_chain_bit) begin
            cfg_enable_d  = 1'b0;
            cfg_bit_d     = 1'b0;
            buf_d         = '0;
            idx_d         = '0;
            done_d        = 1'b1;
            core_enable_d = 1'b1;
          end else if (xfer) begin
            cfg_enable_d = 1'b1;
            cfg_bit_d    = word_data[0];
            buf_d        = word_data >> 1;
            idx_d        = '0;
          end else if (cfg_enable_q && !final_buf_bit) begin
            cfg_bit_d = buf_q[0];
            buf_d     = buf_q >> 1;
            idx_d     = idx_q + IDX_W'(1);
          end else begin
            cfg_enable_d = 1'b0;
            cfg_bit_d    = 1'b0;
            idx_d        = '0;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: unit 0 is a 40-bit chain, unit 1 a 20-bit
// chain, both with 8-bit words and a 2-cycle clear phase.
module tb_config_loader;

  logic       clock = 1'b0;
  logic       nreset;
  logic [1:0] startS, abortS, validS;
  logic [7:0] dataS [2];
  wire  [1:0] readyW, bitW, enW, cfgNrW, coreEnW, busyW, doneW;

  int checks = 0;
  int errors = 0;

  logic [7:0] words [8];
  int   enCount, bitErrs, doneCount, firstEn, lastEn, readyAfterLast, nresetLow;
  logic finished;

  always #5 clock = ~clock;

  config_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dutA (
    .clock(clock), .nreset(nreset), .start(startS[0]), .abort(abortS[0]),
    .word_data(dataS[0]), .word_valid(validS[0]), .word_ready(readyW[0]),
    .cfg_bit(bitW[0]), .cfg_enable(enW[0]), .cfg_nreset(cfgNrW[0]),
    .core_enable(coreEnW[0]), .busy(busyW[0]), .done(doneW[0]));

  config_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dutB (
    .clock(clock), .nreset(nreset), .start(startS[1]), .abort(abortS[1]),
    .word_data(dataS[1]), .word_valid(validS[1]), .word_ready(readyW[1]),
    .cfg_bit(bitW[1]), .cfg_enable(enW[1]), .cfg_nreset(cfgNrW[1]),
    .core_enable(coreEnW[1]), .busy(busyW[1]), .done(doneW[1]));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start and confirm exactly two cycles of configuration reset.
  task automatic startAndClear(input int u);
    startS[u] = 1'b1;
    tick();
    startS[u] = 1'b0;
    checks++;
    if (cfgNrW[u] !== 1'b0 || busyW[u] !== 1'b1) begin
      errors++; $display("[TB] FAIL clear1 u%0d: cfg_nreset=%b busy=%b, want 0 1", u, cfgNrW[u], busyW[u]);
    end
    tick();
    checks++;
    if (cfgNrW[u] !== 1'b0) begin
      errors++; $display("[TB] FAIL clear2 u%0d: cfg_nreset=%b, want 0", u, cfgNrW[u]);
    end
    tick();
    checks++;
    if (cfgNrW[u] !== 1'b1 || readyW[u] !== 1'b1) begin
      errors++; $display("[TB] FAIL load_entry u%0d: cfg_nreset=%b ready=%b, want 1 1", u, cfgNrW[u], readyW[u]);
    end
  endtask

  // Feed words, record shifted bits against words[] LSB-first, stop at done.
  task automatic stream(input int u, input int nw, input int stallAfter, input int stallLen,
                        input int abortBit, input int startBit);
    int   wi, stallRem, idx;
    logic pending, xfer, aborting;
    wi = 0; stallRem = 0; pending = 1'b0; aborting = 1'b0;
    enCount = 0; bitErrs = 0; doneCount = 0; firstEn = -1; lastEn = -1;
    readyAfterLast = 0; nresetLow = 0; finished = 1'b0;
    for (int c = 0; c < 300; c++) begin
      startS[u] = 1'b0;
      abortS[u] = 1'b0;
      if (doneW[u] === 1'b1) begin
        doneCount++;
        finished = 1'b1;
        break;
      end
      if (cfgNrW[u] !== 1'b1) nresetLow++;
      if (wi == nw && readyW[u] === 1'b1) readyAfterLast++;
      if (enW[u] === 1'b1) begin
        idx = enCount;
        if (bitW[u] !== words[idx / 8][idx % 8]) bitErrs++;
        if (firstEn < 0) firstEn = c;
        lastEn = c;
        enCount++;
        if (idx == abortBit) begin abortS[u] = 1'b1; aborting = 1'b1; end
        if (idx == startBit) startS[u] = 1'b1;
      end
      if (pending && readyW[u] === 1'b1) begin stallRem = stallLen; pending = 1'b0; end
      validS[u] = (wi < nw) && (stallRem == 0);
      if (stallRem > 0) stallRem--;
      dataS[u] = (wi < nw) ? words[wi] : 8'h00;
      xfer = validS[u] && readyW[u];
      tick();
      if (xfer) begin
        wi++;
        if (wi == stallAfter) pending = 1'b1;
      end
      if (aborting) break;
    end
    startS[u] = 1'b0;
    abortS[u] = 1'b0;
    validS[u] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({enW[0], cfgNrW[0], coreEnW[0], busyW[0], doneW[0], readyW[0], bitW[0]} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: en/nr/core/busy/done/ready/bit=%b, want 0000000",
                         {enW[0], cfgNrW[0], coreEnW[0], busyW[0], doneW[0], readyW[0], bitW[0]});
    end
    tick();
    nreset = 1'b1;
    tick();
    checks++;
    if (cfgNrW !== 2'b11 || busyW !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_release: cfg_nreset=%b busy=%b, want 11 00", cfgNrW, busyW);
    end
  endtask

  task automatic test_full_load();
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
    startAndClear(0);
    stream(0, 5, -1, 0, -1, -1);
    checks++;
    if (finished !== 1'b1 || enCount != 40) begin
      errors++; $display("[TB] FAIL full_count: finished=%b enables=%0d, want 1 40", finished, enCount);
    end
    checks++;
    if (bitErrs != 0) begin
      errors++; $display("[TB] FAIL full_bits: wrong bits=%0d, want 0", bitErrs);
    end
    checks++;
    if (lastEn - firstEn + 1 != 40) begin
      errors++; $display("[TB] FAIL full_bubbles: enable span=%0d, want 40", lastEn - firstEn + 1);
    end
    checks++;
    if (coreEnW[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL full_core_en_done: core_enable=%b, want 1", coreEnW[0]);
    end
    tick();
    checks++;
    if (doneW[0] !== 1'b0 || busyW[0] !== 1'b0 || coreEnW[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL full_idle: done=%b busy=%b core=%b, want 0 0 1", doneW[0], busyW[0], coreEnW[0]);
    end
  endtask

  task automatic test_partial_word();
    words = '{8'hA5, 8'h3C, 8'hF9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    startAndClear(1);
    stream(1, 3, -1, 0, -1, -1);
    checks++;
    if (finished !== 1'b1 || enCount != 20 || bitErrs != 0) begin
      errors++; $display("[TB] FAIL partial: finished=%b enables=%0d bad=%0d, want 1 20 0", finished, enCount, bitErrs);
    end
    checks++;
    if (readyAfterLast != 0) begin
      errors++; $display("[TB] FAIL partial_ready: ready cycles after last word=%0d, want 0", readyAfterLast);
    end
    tick();
  endtask

  task automatic test_stall();
    words = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    startAndClear(1);
    stream(1, 3, 2, 5, -1, -1);
    checks++;
    if (finished !== 1'b1 || enCount != 20 || bitErrs != 0) begin
      errors++; $display("[TB] FAIL stall: finished=%b enables=%0d bad=%0d, want 1 20 0", finished, enCount, bitErrs);
    end
    checks++;
    if (lastEn - firstEn + 1 - enCount != 5) begin
      errors++; $display("[TB] FAIL stall_gap: idle cycles=%0d, want 5", lastEn - firstEn + 1 - enCount);
    end
    tick();
  endtask

  task automatic test_abort();
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
    startAndClear(0);
    stream(0, 5, -1, 0, 17, -1);
    checks++;
    if (enCount != 18) begin
      errors++; $display("[TB] FAIL abort_point: enables=%0d, want 18", enCount);
    end
    checks++;
    if ({enW[0], coreEnW[0], busyW[0], doneW[0], readyW[0], cfgNrW[0]} !== 6'b000001) begin
      errors++; $display("[TB] FAIL abort_state: en/core/busy/done/ready/nr=%b, want 000001",
                         {enW[0], coreEnW[0], busyW[0], doneW[0], readyW[0], cfgNrW[0]});
    end
    startAndClear(0);
    stream(0, 5, -1, 0, -1, -1);
    checks++;
    if (finished !== 1'b1 || enCount != 40 || bitErrs != 0) begin
      errors++; $display("[TB] FAIL abort_reload: finished=%b enables=%0d bad=%0d, want 1 40 0", finished, enCount, bitErrs);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    words = '{8'h5A, 8'hC3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    startAndClear(1);
    stream(1, 3, -1, 0, -1, 5);
    checks++;
    if (finished !== 1'b1 || enCount != 20 || bitErrs != 0 || nresetLow != 0) begin
      errors++; $display("[TB] FAIL start_in_load: finished=%b enables=%0d bad=%0d nr_low=%0d, want 1 20 0 0",
                         finished, enCount, bitErrs, nresetLow);
    end
    tick();
    startS[1] = 1'b1;
    abortS[1] = 1'b1;
    tick();
    checks++;
    if (busyW[1] !== 1'b0 || cfgNrW[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL start_abort_idle: busy=%b nr=%b, want 0 1", busyW[1], cfgNrW[1]);
    end
    abortS[1] = 1'b0;
    tick();
    startS[1] = 1'b0;
    checks++;
    if (busyW[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL start_after: busy=%b, want 1", busyW[1]);
    end
    startS[1] = 1'b1;
    abortS[1] = 1'b1;
    tick();
    startS[1] = 1'b0;
    abortS[1] = 1'b0;
    checks++;
    if (busyW[1] !== 1'b0 || cfgNrW[1] !== 1'b1 || coreEnW[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL start_abort_clear: busy=%b nr=%b core=%b, want 0 1 0", busyW[1], cfgNrW[1], coreEnW[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    startAndClear(0);
    dataS[0] = 8'hFF;
    validS[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (enW[0] !== 1'b1 || busyW[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL midload_active: en=%b busy=%b, want 1 1", enW[0], busyW[0]);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({enW[0], cfgNrW[0], coreEnW[0], busyW[0], doneW[0], readyW[0], bitW[0]} !== 7'b0) begin
      errors++; $display("[TB] FAIL midload_async: en/nr/core/busy/done/ready/bit=%b, want 0000000",
                         {enW[0], cfgNrW[0], coreEnW[0], busyW[0], doneW[0], readyW[0], bitW[0]});
    end
    validS[0] = 1'b0;
    startS[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (busyW[0] !== 1'b0 || cfgNrW[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL midload_start_in_reset: busy=%b nr=%b, want 0 0", busyW[0], cfgNrW[0]);
    end
    startS[0] = 1'b0;
    nreset = 1'b1;
    tick();
    checks++;
    if (busyW[0] !== 1'b0 || cfgNrW[0] !== 1'b1 || coreEnW[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL midload_release: busy=%b nr=%b core=%b, want 0 1 0", busyW[0], cfgNrW[0], coreEnW[0]);
    end
  endtask

  // Run every scenario in order and report the totals.
  initial begin
    nreset = 1'b0;
    startS = 2'b00;
    abortS = 2'b00;
    validS = 2'b00;
    dataS[0] = 8'h00;
    dataS[1] = 8'h00;
    test_reset();
    test_full_load();
    test_partial_word();
    test_stall();
    test_abort();
    test_start_ignored();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
